// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the keypad pulse encoder.
package keypad_pkg;

  localparam int NUM_KEYS = 10;
  localparam logic [NUM_KEYS-1:0] KEY_IDLE = 10'h3FF;
  localparam logic [3:0] KEY_CODE_NONE = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    EMIT,
    HELD,
    RELEASE_DB
  } kp_state_e;

  // Number of pressed (low) keys in an active-low vector.
  function automatic logic [3:0] onehot_low_count(input logic [NUM_KEYS-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!v[i]) cnt = cnt + 4'd1;
    end
    return cnt;
  endfunction

  // Index of the lowest low bit; KEY_CODE_NONE when no key is pressed.
  function automatic logic [3:0] key_index(input logic [NUM_KEYS-1:0] v);
    logic [3:0] idx;
    idx = KEY_CODE_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (!v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_pulse_encoder_key_sync.sv
// Two-flop synchronizer for asynchronous active-low inputs; resets to all ones
// so that a reset looks like "no key pressed".
module key_sync #(
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/keypad_pulse_encoder.sv
// Keypad front end: synchronize, debounce and turn each press into a one-cycle
// active-low one-hot pulse on A. Optional auto-repeat: KEYPAD_AUTOREPEAT_EN.
module keypad_pulse_encoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] A,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                multi_err
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [NUM_KEYS-1:0] sync_key;
  logic [3:0]          low_cnt;
  logic                key_none;
  logic                key_single;
  logic                key_multi;

  kp_state_e           state_q, state_d;
  logic [NUM_KEYS-1:0] lat_key_q, lat_key_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] a_q, a_d;
  logic [3:0]          code_q, code_d;
  logic                valid_q, valid_d;
  logic                merr_q, merr_d;

  key_sync #(
    .WIDTH(NUM_KEYS)
  ) u_key_sync (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (key_raw),
    .q_o   (sync_key)
  );

  assign low_cnt    = onehot_low_count(sync_key);
  assign key_none   = (sync_key == KEY_IDLE);
  assign key_single = (low_cnt == 4'd1);
  assign key_multi  = (low_cnt >= 4'd2);

  always_comb begin
    state_d   = state_q;
    lat_key_d = lat_key_q;
    cnt_d     = cnt_q;
    merr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_single) begin
          lat_key_d = sync_key;
          cnt_d     = '0;
          state_d   = PRESS_DB;
        end else if (key_multi) begin
          merr_d    = 1'b1;
          lat_key_d = KEY_IDLE;
          cnt_d     = '0;
          state_d   = HELD;
        end
      end
      PRESS_DB: begin
        if (key_multi) begin
          merr_d    = 1'b1;
          lat_key_d = KEY_IDLE;
          cnt_d     = '0;
          state_d   = HELD;
        end else if (key_none) begin
          state_d = IDLE;
        end else if (sync_key == lat_key_q) begin
          if (cnt_q == DB_LAST) state_d = EMIT;
          else                  cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          // A different single key restarts the debounce on the new key.
          lat_key_d = sync_key;
          cnt_d     = '0;
        end
      end
      EMIT: begin
        cnt_d   = '0;
        state_d = HELD;
      end
      HELD: begin
        if (key_none) begin
          cnt_d   = '0;
          state_d = RELEASE_DB;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          if (sync_key == lat_key_q) begin
            if (cnt_q == RPT_LAST) state_d = EMIT;
            else                   cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
`endif
        end
      end
      RELEASE_DB: begin
        if (!key_none) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered on the edge that enters EMIT.
  always_comb begin
    a_d     = KEY_IDLE;
    code_d  = KEY_CODE_NONE;
    valid_d = 1'b0;
    if (state_d == EMIT) begin
      a_d     = lat_key_q;
      code_d  = key_index(lat_key_q);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      lat_key_q <= KEY_IDLE;
      cnt_q     <= '0;
      a_q       <= KEY_IDLE;
      code_q    <= KEY_CODE_NONE;
      valid_q   <= 1'b0;
      merr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_key_q <= lat_key_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      merr_q    <= merr_d;
    end
  end

  assign A         = a_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign multi_err = merr_q;

endmodule

// File: tb/tb_keypad_pulse_encoder.sv
// Bench for keypad_pulse_encoder with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=64.
// Build with +define+KEYPAD_AUTOREPEAT_EN to cover the auto-repeat variant.
module tb_keypad_pulse_encoder;

  localparam int D = 4;
  localparam int R = 64;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] key_raw;
  logic [9:0] A;
  logic [3:0] key_code;
  logic       key_valid;
  logic       multi_err;

  always #5 clk = ~clk;

  keypad_pulse_encoder #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_raw  (key_raw),
    .A        (A),
    .key_code (key_code),
    .key_valid(key_valid),
    .multi_err(multi_err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Works on run lengths of the twice-delayed key vector: a press fires once a
  // single-key vector has been seen D+1 times in a row while armed; re-arming
  // needs D+1 consecutive released samples.
  logic [9:0] sh1, sh2, run_vec, lat_vec;
  int         run_len, rel_len, rep_len;
  bit         armed, skip;
  logic [9:0] m_a;
  logic [3:0] m_code;
  logic       m_valid, m_merr;

  task automatic model_reset();
    sh1 = 10'h3FF; sh2 = 10'h3FF; run_vec = 10'h3FF; lat_vec = 10'h3FF;
    run_len = 0; rel_len = 0; rep_len = 0; armed = 1'b1; skip = 1'b0;
    m_a = 10'h3FF; m_code = 4'hF; m_valid = 1'b0; m_merr = 1'b0;
  endtask

  task automatic emit(input logic [9:0] v);
    m_a = v; m_valid = 1'b1; skip = 1'b1;
    for (int i = 9; i >= 0; i--) if (!v[i]) m_code = 4'(i);
  endtask

  task automatic model_step(input logic [9:0] raw);
    logic [9:0] s;
    s = sh2; sh2 = sh1; sh1 = raw;
    m_a = 10'h3FF; m_code = 4'hF; m_valid = 1'b0; m_merr = 1'b0;
    if (skip) begin
      skip = 1'b0; rep_len = 0; rel_len = 0;
    end else if (armed) begin
      if (s == 10'h3FF) run_len = 0;
      else if ($countones(~s) >= 2) begin
        m_merr = 1'b1; armed = 1'b0; lat_vec = 10'h3FF; rel_len = 0; rep_len = 0;
      end else if (run_len > 0 && s == run_vec) run_len++;
      else begin
        run_vec = s; run_len = 1;
      end
      if (armed && run_len == D + 1) begin
        emit(run_vec); armed = 1'b0; lat_vec = run_vec;
      end
    end else begin
      if (s == 10'h3FF) begin
        rel_len++; rep_len = 0;
        if (rel_len == D + 1) begin
          armed = 1'b1; run_len = 0; rel_len = 0;
        end
      end else if (rel_len > 0) begin
        rel_len = 0; rep_len = 0;
      end else if (s == lat_vec) begin
        rep_len++;
`ifdef KEYPAD_AUTOREPEAT_EN
        if (rep_len == R) emit(lat_vec);
`endif
      end else begin
        rep_len = 0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];
  logic [3:0] exp_code_q[$];
  int         exp_off_q[$];
  logic [9:0] obs_a_q[$];
  logic [3:0] obs_code_q[$];
  int         obs_cyc_q[$];
  int         merr_cyc_q[$];

  // Compare process: checks every cycle 1 time unit after the rising edge.
  always begin
    logic [9:0] samp;
    @(posedge clk);
    samp = key_raw;
    #1;
    cyc++;
    if (!rst) model_reset();
    else      model_step(samp);
    check("cycle_outputs", {16'h0, A, key_code, key_valid, multi_err},
          {16'h0, m_a, m_code, m_valid, m_merr});
    if (key_valid) begin
      obs_a_q.push_back(A);
      obs_code_q.push_back(key_code);
      obs_cyc_q.push_back(cyc);
    end
    if (multi_err) merr_cyc_q.push_back(cyc);
  end

  task automatic clear_logs();
    exp_q.delete(); exp_code_q.delete(); exp_off_q.delete();
    obs_a_q.delete(); obs_code_q.delete(); obs_cyc_q.delete(); merr_cyc_q.delete();
  endtask

  task automatic expect_pulse(input logic [9:0] a, input logic [3:0] code, input int off);
    exp_q.push_back(a); exp_code_q.push_back(code); exp_off_q.push_back(off);
  endtask

  task automatic end_test(input string name, input int start);
    check({name, "_pulse_count"}, obs_a_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_a_q.size() > 0) begin
      check({name, "_A"}, obs_a_q.pop_front(), exp_q.pop_front());
      check({name, "_code"}, obs_code_q.pop_front(), exp_code_q.pop_front());
      check({name, "_edge"}, obs_cyc_q.pop_front() - start, exp_off_q.pop_front());
    end
    clear_logs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic hold(input logic [9:0] v, input int n);
    key_raw = v;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start;
    rst = 1'b0;
    key_raw = 10'h3FF;
    repeat (3) @(negedge clk);
    check("reset_A", A, 10'h3FF);
    check("reset_code", key_code, 4'hF);
    check("reset_valid", key_valid, 1'b0);
    check("reset_merr", multi_err, 1'b0);
    rst = 1'b1;
    clear_logs();
    hold(10'h3FF, 10);
    end_test("idle_after_reset", cyc + 1);

    // Clean press of key 5.
    start = cyc + 1;
    expect_pulse(10'h3DF, 4'd5, 6);
    hold(10'h3DF, 30);
    hold(10'h3FF, 12);
    end_test("press5", start);

    // Bounce on key 2, then stable.
    hold(10'h3FB, 2);
    hold(10'h3FF, 1);
    hold(10'h3FB, 1);
    hold(10'h3FF, 1);
    start = cyc + 1;
    expect_pulse(10'h3FB, 4'd2, 6);
    hold(10'h3FB, 20);
    hold(10'h3FF, 12);
    end_test("bounce2", start);

    // Keys 3 and 7 together, then release key 3 only.
    start = cyc + 1;
    hold(10'h377, 10);
    hold(10'h37F, 20);
    hold(10'h3FF, 12);
    check("multi_err_count", merr_cyc_q.size(), 1);
    if (merr_cyc_q.size() > 0) check("multi_err_edge", merr_cyc_q[0] - start, 2);
    end_test("multi_no_pulse", start);
    start = cyc + 1;
    expect_pulse(10'h3F7, 4'd3, 6);
    hold(10'h3F7, 15);
    hold(10'h3FF, 12);
    end_test("press3_after_multi", start);

    // Reset asserted while the pulse is on A: outputs go idle at once.
    start = cyc + 1;
    expect_pulse(10'h3FD, 4'd1, 6);
    hold(10'h3FD, 7);
    check("pulse_before_async_reset", A, 10'h3FD);
    rst = 1'b0;
    #1;
    check("async_reset_A", A, 10'h3FF);
    check("async_reset_valid", key_valid, 1'b0);
    check("async_reset_code", key_code, 4'hF);
    hold(10'h3FF, 2);
    rst = 1'b1;
    hold(10'h3FF, 10);
    end_test("async_reset", start);

    // Reset mid-debounce with key 9 held through it.
    hold(10'h1FF, 3);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start = cyc + 1;
    expect_pulse(10'h1FF, 4'd9, 6);
    hold(10'h1FF, 20);
    hold(10'h3FF, 12);
    end_test("reset_mid_debounce", start);

    // Long hold of key 0.
    start = cyc + 1;
    expect_pulse(10'h3FE, 4'd0, 6);
`ifdef KEYPAD_AUTOREPEAT_EN
    expect_pulse(10'h3FE, 4'd0, 71);
    expect_pulse(10'h3FE, 4'd0, 136);
`endif
    hold(10'h3FE, 200);
    hold(10'h3FF, 12);
    end_test("long_hold0", start);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
